uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered, runtime-configurable UART transmitter. It replaces the fixed-format transmitter on the UPDI link path. An internal FIFO decouples the command sequencer from line timing. Baud divisor, parity mode, stop bits and inter-frame guard time are configured at runtime. It also generates BREAK conditions (long low pulses) that UPDI uses for link reset/resync.

## Interface
- `DATA_BITS`, 8: frame data width, 5–9.
- `FIFO_DEPTH`, 16: entries, power of two, ≥2.
- `BREAK_BITS`, 12: bit-times of low level for a BREAK.
- `DIV_W`, 16: width of divisor input.
- `clk` in 1: logic clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in DATA_BITS: word to enqueue.
- `tx_push` in 1: enqueue strobe; ignored when `fifo_full`.
- `fifo_full` out 1: FIFO holds FIFO_DEPTH words.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: occupancy.
- `overflow` out 1: one-cycle pulse when `tx_push` is asserted while full.
- `cfg_div` in DIV_W: clocks per bit; values <2 are treated as 2.
- `cfg_parity` in 2: 0 none, 1 even, 2 odd, 3 treated as none.
- `cfg_stop2` in 1: 0 = one stop bit, 1 = two.
- `cfg_guard` in 4: idle bit-times inserted after every frame/break, 0–15.
- `brk_req` in 1: pulse; requests one BREAK.
- `busy` out 1: a frame, break or guard is in progress.
- `tx` out 1: serial line, idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK, GUARD.
- The block samples all `cfg_*` inputs into shadow registers on leaving IDLE. Config changes mid-frame take effect on the next frame only.
- IDLE: `tx`=1.
  - A pending break has priority: go to BREAK.
  - Otherwise, if the FIFO is non-empty: pop, latch the word, go to START.
- START: `tx`=0 for one bit-time.
- DATA: LSB first, DATA_BITS bit-times.
- PARITY: only if parity is enabled. Even means the count of ones over data+parity is even; odd means it is odd.
- STOP: `tx`=1 for 1 or 2 bit-times.
- BREAK: `tx`=0 for BREAK_BITS bit-times, then `tx`=1 for the stop bit-time(s).
- GUARD: `tx`=1 for `cfg_guard` bit-times. The block skips GUARD when the guard value is 0. GUARD returns to IDLE.
- `brk_req` sets a sticky pending flag. The flag clears on entry to BREAK. A request during a frame is serviced after that frame's STOP+GUARD, before the next FIFO word. Multiple requests while pending coalesce into one BREAK.
- FIFO:
  - A push when full is dropped and `overflow` pulses.
  - A push and pop in the same cycle at non-full keeps the level unchanged.
  - A push into an empty FIFO is popped no earlier than the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- `busy` = state != IDLE.

## Timing
- Bit-time = D clocks, where D = max(shadow `cfg_div`, 2). The bit-time counter reloads at each bit boundary, so there is no drift.
- Latency: with the block idle and the FIFO empty, `tx_push` in cycle N gives a pop in N+1 and `tx` low from N+2.
- Back-to-back frames have no extra idle cycles beyond guard bit-times.
- Frame length in clocks: D × (1 + DATA_BITS + P + S + G), where:
  - P is 1 if parity is enabled, else 0.
  - S is 1 or 2 stop bits.
  - G is `cfg_guard`.
- `tx` is registered, with no combinational path from inputs.
- Reset (asynchronous, any time including mid-frame) takes effect immediately:
  - `tx`=1, state IDLE.
  - FIFO empty, `fifo_level`=0, `fifo_full`=0.
  - `overflow`=0, `busy`=0, break pending cleared.

## Structure
- `uart_pkg`:
  - `uart_state` enum extended with `UART_BREAK` and `UART_GUARD`.
  - `uart_parity_e` {NONE, EVEN, ODD}.
- Sub-module `sync_fifo`:
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
  - Async active-low reset.
  - Reusable for the RX side.
- Parity is computed inline from the latched word; there is no separate clock divider instance.

## Test plan
- DATA_BITS=8, cfg_div=4, no parity, 1 stop, guard 0. Push 0xA5 → `tx`: 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; first low at push+2; `busy` for 40 clocks.
- cfg_parity=1 (even), cfg_stop2=1, cfg_guard=2, cfg_div=3. Push 0x55 → parity bit 0, two stop bits, line high for an extra 6 clocks before the next start.
- FIFO_DEPTH=4. Push 6 words in 6 consecutive cycles while transmitting → 4 accepted (first popped, `fifo_full` asserts), ≥1 `overflow` pulse; accepted words emitted in order.
- `brk_req` mid-frame with 2 words queued → current frame completes, then 12 bit-times low plus stop, then the queued words; a second `brk_req` while pending produces no extra BREAK.
- Change cfg_div from 4 to 8 during a frame → the current frame stays at 4 clocks/bit and the next frame uses 8; cfg_div=0 gives 2 clocks/bit.
- Deassert `rst_n` mid-DATA with 3 words queued → `tx`=1 immediately, `fifo_level`=0; after release, no stale data is transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART blocks: transmitter FSM states and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP,
    UART_BREAK,
    UART_GUARD
  } uart_state_e;

  typedef enum logic [1:0] {
    UART_PAR_NONE = 2'd0,
    UART_PAR_EVEN = 2'd1,
    UART_PAR_ODD  = 2'd2
  } uart_parity_e;

  // Encoding 3 is reserved and behaves as no parity.
  function automatic uart_parity_e decode_parity(input logic [1:0] mode);
    uart_parity_e par;
    case (mode)
      2'd1:    par = UART_PAR_EVEN;
      2'd2:    par = UART_PAR_ODD;
      default: par = UART_PAR_NONE;
    endcase
    return par;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout_o shows the head entry whenever not empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with runtime framing config, BREAK generation and guard time.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BREAK_BITS = 12,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DATA_BITS-1:0]          tx_data_i,
  input  logic                          tx_push_i,
  output logic                          fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  input  logic [DIV_W-1:0]              cfg_div_i,
  input  logic [1:0]                    cfg_parity_i,
  input  logic                          cfg_stop2_i,
  input  logic [3:0]                    cfg_guard_i,
  input  logic                          brk_req_i,
  output logic                          busy_o,
  output logic                          tx_o
);

  localparam int unsigned MaxBits = (BREAK_BITS > 16) ? BREAK_BITS : 16;
  localparam int unsigned BitW    = $clog2(MaxBits) + 1;
  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(2);

  uart_state_e          state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic                 tx_q, tx_d;
  logic [DIV_W-1:0]     div_q, div_d;
  uart_parity_e         par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic [3:0]           guard_q, guard_d;
  logic                 brk_pend_q, brk_pend_d;
  logic                 ovf_q, ovf_d;

  logic                 fifo_pop, fifo_empty, fifo_full;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [DIV_W-1:0]     div_in_eff;
  logic [DATA_BITS-1:0] data_shift;
  logic                 bit_end, par_bit, launch;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_push_i),
    .pop_i   (fifo_pop),
    .din_i   (tx_data_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign div_in_eff = (cfg_div_i < MinDiv) ? MinDiv : cfg_div_i;
  assign bit_end    = (cnt_q == '0);
  assign data_shift = word_q >> (bit_q + BitW'(1));
  assign par_bit    = (^word_q) ^ (par_q == UART_PAR_ODD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    word_d     = word_q;
    tx_d       = tx_q;
    div_d      = div_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    guard_d    = guard_q;
    brk_pend_d = brk_pend_q | brk_req_i;
    ovf_d      = tx_push_i & fifo_full;
    fifo_pop   = 1'b0;
    launch     = 1'b0;

    // Reload at every bit boundary so bit-times never drift.
    if (state_q != UART_IDLE) begin
      cnt_d = bit_end ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
    end

    unique case (state_q)
      UART_IDLE: launch = 1'b1;
      UART_START: begin
        if (bit_end) begin
          state_d = UART_DATA;
          bit_d   = '0;
          tx_d    = word_q[0];
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (par_q != UART_PAR_NONE) begin
              state_d = UART_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = UART_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
            tx_d  = data_shift[0];
          end
        end
      end
      UART_PARITY: begin
        if (bit_end) begin
          state_d = UART_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      UART_BREAK: begin
        if (bit_end) begin
          if (bit_q == BitW'(BREAK_BITS - 1)) begin
            state_d = UART_STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      UART_STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d = BitW'(1);
          end else if (guard_q != '0) begin
            state_d = UART_GUARD;
            bit_d   = '0;
          end else begin
            launch = 1'b1;
          end
        end
      end
      UART_GUARD: begin
        if (bit_end) begin
          if (bit_q == (BitW'(guard_q) - BitW'(1))) begin
            launch = 1'b1;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = UART_IDLE;
    endcase

    // Frame boundary: chain straight into the next job so back-to-back frames add no idle clocks.
    if (launch) begin
      state_d = UART_IDLE;
      tx_d    = 1'b1;
      bit_d   = '0;
      if (brk_pend_q || !fifo_empty) begin
        div_d      = div_in_eff;
        par_d      = decode_parity(cfg_parity_i);
        stop2_d    = cfg_stop2_i;
        guard_d    = cfg_guard_i;
        cnt_d      = div_in_eff - DIV_W'(1);
        tx_d       = 1'b0;
        if (brk_pend_q) begin
          state_d    = UART_BREAK;
          brk_pend_d = 1'b0;
        end else begin
          state_d  = UART_START;
          fifo_pop = 1'b1;
          word_d   = fifo_dout;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= UART_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      div_q      <= MinDiv;
      par_q      <= UART_PAR_NONE;
      stop2_q    <= 1'b0;
      guard_q    <= '0;
      brk_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      div_q      <= div_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      guard_q    <= guard_d;
      brk_pend_q <= brk_pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign fifo_full_o = fifo_full;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q != UART_IDLE);
  assign tx_o        = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table plus directed FIFO/BREAK/config/reset sequences.
module tb_uart_tx_fifo;

  localparam int unsigned DataBits = 8;
  localparam int unsigned Depth    = 4;
  localparam int unsigned BrkBits  = 12;
  localparam int unsigned DivW     = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      tx_data;
  logic            tx_push;
  logic            fifo_full;
  logic [2:0]      fifo_level;
  logic            overflow;
  logic [DivW-1:0] cfg_div;
  logic [1:0]      cfg_parity;
  logic            cfg_stop2;
  logic [3:0]      cfg_guard;
  logic            brk_req;
  logic            busy;
  logic            tx;

  uart_tx_fifo #(
    .DATA_BITS  (DataBits),
    .FIFO_DEPTH (Depth),
    .BREAK_BITS (BrkBits),
    .DIV_W      (DivW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tx_data_i    (tx_data),
    .tx_push_i    (tx_push),
    .fifo_full_o  (fifo_full),
    .fifo_level_o (fifo_level),
    .overflow_o   (overflow),
    .cfg_div_i    (cfg_div),
    .cfg_parity_i (cfg_parity),
    .cfg_stop2_i  (cfg_stop2),
    .cfg_guard_i  (cfg_guard),
    .brk_req_i    (brk_req),
    .busy_o       (busy),
    .tx_o         (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_brk;
    logic [7:0] data;
    int         div;
    int         par;
    bit         stop2;
    int         guard;
  } frame_t;

  typedef struct {
    int         div;
    int         par;
    bit         stop2;
    int         guard;
    logic [7:0] data;
    int         exp_busy;
  } vec_t;

  frame_t sb[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     ovf_cnt = 0;
  bit     mon_busy = 1'b0;

  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic bit parity_of(input logic [7:0] d, input int p);
    bit x = 1'b0;
    for (int i = 0; i < 8; i++) x ^= d[i];
    return (p == 2) ? ~x : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int d, input int p, input bit s2, input int g);
    cfg_div    = DivW'(d);
    cfg_parity = 2'(p);
    cfg_stop2  = s2;
    cfg_guard  = 4'(g);
  endtask

  function automatic frame_t mk(input bit brk, input logic [7:0] d);
    frame_t f;
    f.is_brk = brk;
    f.data   = d;
    f.div    = int'(cfg_div);
    f.par    = int'(cfg_parity);
    f.stop2  = cfg_stop2;
    f.guard  = int'(cfg_guard);
    return f;
  endfunction

  task automatic wait_low(input string name, input int limit);
    int c = 0;
    while (tx !== 1'b0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL %s start_timeout: tx=%b after %0d clocks, expected 0", name, tx, c);
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int c = 0;
    bit done = 1'b0;
    while (!done && c < limit) begin
      @(negedge clk);
      #1;
      c++;
      done = (sb.size() == 0) && !mon_busy && (busy === 1'b0);
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s drain: %0d frames outstanding, busy=%b after %0d clocks, expected 0/0",
               name, sb.size(), busy, c);
    end
  endtask

  always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

  // Line monitor: on each start edge, pop the next expected frame and check every clock of it.
  initial begin : mon
    bit     prev;
    frame_t f;
    bit     eb[32];
    int     nb, d, bad;
    logic   badv;
    bit     aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
      end else if (prev && tx === 1'b0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: tx fell low at %0t, expected idle high", $time);
        end else begin
          mon_busy = 1'b1;
          f  = sb.pop_front();
          d  = eff_div(f.div);
          nb = 0;
          if (f.is_brk) begin
            for (int i = 0; i < BrkBits; i++) eb[nb++] = 1'b0;
          end else begin
            eb[nb++] = 1'b0;
            for (int i = 0; i < 8; i++) eb[nb++] = f.data[i];
            if (f.par == 1 || f.par == 2) eb[nb++] = parity_of(f.data, f.par);
          end
          eb[nb++] = 1'b1;
          if (f.stop2) eb[nb++] = 1'b1;
          for (int i = 0; i < f.guard; i++) eb[nb++] = 1'b1;
          bad = -1;
          badv = 1'b0;
          aborted = 1'b0;
          for (int k = 0; k < nb * d; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== eb[k / d] && bad < 0) begin
              bad  = k;
              badv = tx;
            end
          end
          if (!aborted) begin
            n_cmp++;
            if (bad >= 0) begin
              n_err++;
              $display("FAIL frame(data=%02h brk=%0d div=%0d): clock %0d bit %0d tx=%b expected %b",
                       f.data, f.is_brk, d, bad, bad / d, badv, eb[bad / d]);
            end
          end
          mon_busy = 1'b0;
        end
      end
      prev = (tx === 1'b1);
    end
  end

  initial begin : main
    vec_t vecs[6];
    int   lat, bcnt, ovf0;

    vecs[0] = '{div: 4, par: 0, stop2: 1'b0, guard: 0, data: 8'hA5, exp_busy: 40};
    vecs[1] = '{div: 3, par: 1, stop2: 1'b1, guard: 2, data: 8'h55, exp_busy: 42};
    vecs[2] = '{div: 0, par: 2, stop2: 1'b0, guard: 0, data: 8'h01, exp_busy: 22};
    vecs[3] = '{div: 1, par: 3, stop2: 1'b1, guard: 3, data: 8'hFF, exp_busy: 28};
    vecs[4] = '{div: 5, par: 2, stop2: 1'b0, guard: 1, data: 8'h80, exp_busy: 60};
    vecs[5] = '{div: 2, par: 1, stop2: 1'b0, guard: 0, data: 8'h00, exp_busy: 22};

    rst_n   = 1'b0;
    tx_data = '0;
    tx_push = 1'b0;
    brk_req = 1'b0;
    set_cfg(4, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_level", fifo_level, 0);
    check("reset_full", fifo_full, 0);
    check("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames: latency, busy duration and waveform under each config.
    for (int v = 0; v < 6; v++) begin
      set_cfg(vecs[v].div, vecs[v].par, vecs[v].stop2, vecs[v].guard);
      @(negedge clk);
      sb.push_back(mk(1'b0, vecs[v].data));
      tx_data = vecs[v].data;
      tx_push = 1'b1;
      lat  = -1;
      bcnt = 0;
      for (int c = 1; c <= 2000; c++) begin
        @(negedge clk);
        tx_push = 1'b0;
        if (lat < 0 && tx === 1'b0) lat = c;
        if (busy === 1'b1) bcnt++;
        else if (bcnt > 0) break;
      end
      check($sformatf("vec%0d_latency", v), lat, 2);
      check($sformatf("vec%0d_busy_clocks", v), bcnt, vecs[v].exp_busy);
      wait_drain($sformatf("vec%0d", v), 500);
      check($sformatf("vec%0d_level", v), fifo_level, 0);
    end

    // FIFO fill and overflow while a frame is on the line.
    set_cfg(4, 0, 1'b0, 0);
    ovf0 = ovf_cnt;
    @(negedge clk);
    sb.push_back(mk(1'b0, 8'hC3));
    tx_data = 8'hC3;
    tx_push = 1'b1;
    @(negedge clk);
    tx_push = 1'b0;
    wait_low("ovf_pre", 20);
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'h10 + 8'(i);
      tx_push = 1'b1;
      if (i < 4) sb.push_back(mk(1'b0, 8'h10 + 8'(i)));
      @(negedge clk);
    end
    tx_push = 1'b0;
    #1;
    check("ovf_full", fifo_full, 1);
    check("ovf_level", fifo_level, 4);
    check("ovf_pulses", ovf_cnt - ovf0, 2);
    @(negedge clk);
    check("ovf_pulse_ends", overflow, 0);
    wait_drain("ovf", 2000);

    // BREAK requested mid-frame with two words queued; a second request coalesces.
    set_cfg(4, 0, 1'b0, 1);
    @(negedge clk);
    sb.push_back(mk(1'b0, 8'h5A));
    tx_data = 8'h5A;
    tx_push = 1'b1;
    @(negedge clk);
    tx_push = 1'b0;
    wait_low("brk_first", 20);
    tx_data = 8'h11;
    tx_push = 1'b1;
    sb.push_back(mk(1'b0, 8'h11));
    @(negedge clk);
    tx_data = 8'h22;
    sb.push_back(mk(1'b0, 8'h22));
    @(negedge clk);
    tx_push = 1'b0;
    repeat (8) @(negedge clk);
    brk_req = 1'b1;
    sb.push_front(mk(1'b1, 8'h00));
    @(negedge clk);
    brk_req = 1'b0;
    repeat (6) @(negedge clk);
    brk_req = 1'b1;
    @(negedge clk);
    brk_req = 1'b0;
    wait_drain("brk", 3000);
    repeat (100) @(negedge clk);
    check("brk_idle_tx", tx, 1);
    check("brk_idle_busy", busy, 0);

    // Divisor change mid-frame applies to the next frame only.
    set_cfg(4, 0, 1'b0, 0);
    @(negedge clk);
    sb.push_back(mk(1'b0, 8'h96));
    tx_data = 8'h96;
    tx_push = 1'b1;
    @(negedge clk);
    sb.push_back('{is_brk: 1'b0, data: 8'h3C, div: 8, par: 0, stop2: 1'b0, guard: 0});
    tx_data = 8'h3C;
    @(negedge clk);
    tx_push = 1'b0;
    wait_low("div_change", 20);
    cfg_div = DivW'(8);
    wait_drain("div_change", 2000);

    // Asynchronous reset mid-DATA with words queued.
    set_cfg(4, 0, 1'b0, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'hE0 + 8'(i);
      tx_push = 1'b1;
      sb.push_back(mk(1'b0, 8'hE0 + 8'(i)));
      @(negedge clk);
    end
    tx_push = 1'b0;
    wait_low("rst_frame", 20);
    repeat (12) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_level", fifo_level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_level", fifo_level, 0);
    check("rst_full", fifo_full, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("post_rst_tx", tx, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_level", fifo_level, 0);

    set_cfg(2, 1, 1'b1, 1);
    @(negedge clk);
    sb.push_back(mk(1'b0, 8'h3C));
    tx_data = 8'h3C;
    tx_push = 1'b1;
    @(negedge clk);
    tx_push = 1'b0;
    wait_drain("post_rst_frame", 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
